// File: rtl/adc_stats_accum.sv
// ADC slice statistics: windowed sum, average and dead-zone histogram.
// Window length, bin width and dead zone are latched at each window start.
module adc_stats_accum #(
  parameter int Nadc   = 8,
  parameter int Nrange = 4,
  parameter int Nsum   = 24
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      en,
  input  logic signed [Nadc-1:0]    din,
  input  logic [Nrange-1:0]         Navg,
  input  logic [Nrange-1:0]         Nbin,
  input  logic [Nrange-1:0]         DZ,
  output logic signed [Nsum-1:0]    adcout_sum,
  output logic signed [Nadc-1:0]    adcout_avg,
  output logic [(2**Nrange)-1:0]    adcout_hist_center,
  output logic [(2**Nrange)-1:0]    adcout_hist_side,
  output logic                      upd
);

  localparam int HW = 2**Nrange;
  localparam int MW = Nadc + 1;
  localparam int LW = Nrange + 1;
  localparam int CW = (MW > LW) ? MW : LW;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    UPDATE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic start;
  logic step;
  logic finish;

  logic [Nrange-1:0] nav_s;
  logic [Nrange-1:0] nbin_s;
  logic [Nrange-1:0] dz_s;

  logic signed [Nsum-1:0] acc;
  logic signed [Nsum-1:0] acc_nxt;
  logic [HW-1:0] cnt;
  logic [HW-1:0] cnt_last;
  logic [HW-1:0] ctr_c;
  logic [HW-1:0] ctr_s;
  logic [HW-1:0] ctr_c_nxt;
  logic [HW-1:0] ctr_s_nxt;

  logic [MW-1:0] din_x;
  logic [MW-1:0] mag;
  logic [LW-1:0] lim;
  logic          in_c;
  logic          in_s;
  logic          last;

  // One extra bit keeps |most-negative| representable.
  assign din_x = {din[Nadc-1], din};
  assign mag   = din[Nadc-1] ? -din_x : din_x;
  assign lim   = {1'b0, dz_s} + {1'b0, nbin_s};
  assign in_c  = CW'(mag) <= CW'(dz_s);
  assign in_s  = !in_c && (CW'(mag) <= CW'(lim));

  assign acc_nxt =
    acc + $signed({{(Nsum-Nadc){din[Nadc-1]}}, din});
  assign ctr_c_nxt = ctr_c + HW'(in_c);
  assign ctr_s_nxt = ctr_s + HW'(in_s);

  assign cnt_last = ~({HW{1'b1}} << nav_s);
  assign last     = (cnt == cnt_last);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          start     = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (!en) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            finish    = 1'b1;
            state_nxt = UPDATE;
          end
        end
      end
      UPDATE: begin
        if (en) begin
          start     = 1'b1;
          state_nxt = ACCUM;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      nav_s  <= '0;
      nbin_s <= '0;
      dz_s   <= '0;
      acc    <= '0;
      cnt    <= '0;
      ctr_c  <= '0;
      ctr_s  <= '0;
    end else if (start) begin
      nav_s  <= Navg;
      nbin_s <= Nbin;
      dz_s   <= DZ;
      acc    <= '0;
      cnt    <= '0;
      ctr_c  <= '0;
      ctr_s  <= '0;
    end else if (step) begin
      acc   <= acc_nxt;
      cnt   <= cnt + 1'b1;
      ctr_c <= ctr_c_nxt;
      ctr_s <= ctr_s_nxt;
    end
  end

  // Results are taken from the last sample's sums so upd lands next cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      adcout_sum         <= '0;
      adcout_avg         <= '0;
      adcout_hist_center <= '0;
      adcout_hist_side   <= '0;
      upd                <= 1'b0;
    end else begin
      upd <= finish;
      if (finish) begin
        adcout_sum         <= acc_nxt;
        adcout_avg         <= Nadc'(acc_nxt >>> nav_s);
        adcout_hist_center <= ctr_c_nxt;
        adcout_hist_side   <= ctr_s_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adc_stats_accum.sv
// Bench for adc_stats_accum: directed windows plus random stimulus
// against a sample-queue reference model.
module tb_adc_stats_accum;

  logic clk = 1'b0;
  logic rstb;
  logic en;
  logic signed [7:0] din;
  logic [3:0] Navg;
  logic [3:0] Nbin;
  logic [3:0] DZ;
  logic signed [23:0] adcout_sum;
  logic signed [7:0] adcout_avg;
  logic [15:0] adcout_hist_center;
  logic [15:0] adcout_hist_side;
  logic upd;

  int n_chk = 0;
  int n_bad = 0;

  logic signed [23:0] e_sum;
  logic signed [7:0] e_avg;
  logic [15:0] e_hc;
  logic [15:0] e_hs;
  logic e_upd;

  bit running;
  int m_nav;
  int m_nbin;
  int m_dz;
  int q[$];

  adc_stats_accum dut (
    .clk(clk),
    .rstb(rstb),
    .en(en),
    .din(din),
    .Navg(Navg),
    .Nbin(Nbin),
    .DZ(DZ),
    .adcout_sum(adcout_sum),
    .adcout_avg(adcout_avg),
    .adcout_hist_center(adcout_hist_center),
    .adcout_hist_side(adcout_hist_side),
    .upd(upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    running = 1'b0;
    q.delete();
    e_sum = '0;
    e_avg = '0;
    e_hc  = '0;
    e_hs  = '0;
    e_upd = 1'b0;
  endtask

  task automatic close_window();
    longint s = 0;
    longint d;
    longint avg;
    int c = 0;
    int sd = 0;
    foreach (q[i]) begin
      int a;
      s += q[i];
      a = (q[i] < 0) ? -q[i] : q[i];
      if (a <= m_dz) c++;
      else if (a <= m_dz + m_nbin) sd++;
    end
    d = longint'(1) << m_nav;
    avg = (s >= 0) ? s / d : -((-s + d - 1) / d);
    e_sum = 24'(s);
    e_avg = 8'(avg);
    e_hc  = 16'(c);
    e_hs  = 16'(sd);
    e_upd = 1'b1;
  endtask

  task automatic model_step();
    e_upd = 1'b0;
    if (!running) begin
      if (en) begin
        running = 1'b1;
        m_nav  = int'(Navg);
        m_nbin = int'(Nbin);
        m_dz   = int'(DZ);
        q.delete();
      end
    end else if (!en) begin
      running = 1'b0;
    end else begin
      q.push_back(int'(din));
      if (q.size() == (1 << m_nav)) begin
        close_window();
        running = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string p);
    check({p, "_upd"}, upd, e_upd);
    check({p, "_sum"}, adcout_sum, e_sum);
    check({p, "_avg"}, adcout_avg, e_avg);
    check({p, "_hc"}, adcout_hist_center, e_hc);
    check({p, "_hs"}, adcout_hist_side, e_hs);
  endtask

  task automatic tick(input logic e, input int d);
    en  = e;
    din = 8'(d);
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
  endtask

  task automatic cfg(input int na, input int nb, input int dz);
    Navg = 4'(na);
    Nbin = 4'(nb);
    DZ   = 4'(dz);
  endtask

  initial begin
    rstb = 1'b0;
    en   = 1'b0;
    din  = '0;
    cfg(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    #2 rstb = 1'b1;

    // 1..4 over a 4-sample window
    cfg(2, 0, 0);
    tick(1, 0);
    for (int i = 1; i <= 4; i++) tick(1, i);
    check("r32_upd", upd, 1);
    check("r32_sum", adcout_sum, 10);
    check("r32_avg", adcout_avg, 2);
    tick(0, 0);

    // constant -5, back-to-back windows
    cfg(3, 0, 0);
    tick(1, 0);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) tick(1, -5);
      check("r33_sum", adcout_sum, -40);
      check("r33_avg", adcout_avg, -5);
      tick(1, -5);
    end
    tick(0, 0);

    // histogram boundaries incl. -128
    cfg(3, 3, 2);
    tick(1, 0);
    tick(1, 0); tick(1, 2); tick(1, -3); tick(1, 5);
    tick(1, 6); tick(1, -128); tick(1, 1); tick(1, -5);
    check("r34_hc", adcout_hist_center, 3);
    check("r34_hs", adcout_hist_side, 3);
    tick(0, 0);

    // Navg change mid-window
    cfg(2, 0, 0);
    tick(1, 0);
    tick(1, 1); tick(1, 1);
    cfg(4, 0, 0);
    tick(1, 1); tick(1, 1);
    check("r35_upd4", upd, 1);
    check("r35_sum4", adcout_sum, 4);
    tick(1, 0);
    for (int i = 0; i < 16; i++) tick(1, 1);
    check("r35_upd16", upd, 1);
    check("r35_sum16", adcout_sum, 16);
    tick(0, 0);

    // abort mid-window
    cfg(3, 0, 0);
    tick(1, 0);
    for (int i = 0; i < 8; i++) tick(1, 2);
    tick(1, 9);
    for (int i = 0; i < 4; i++) tick(1, 7);
    tick(0, 7);
    for (int i = 0; i < 3; i++) tick(0, 0);
    check("r36_hold", adcout_sum, 16);
    check("r36_noupd", upd, 0);
    tick(1, 0);
    for (int i = 0; i < 8; i++) tick(1, 3);
    check("r36_sum", adcout_sum, 24);
    check("r36_avg", adcout_avg, 3);
    tick(0, 0);

    // Navg=0 single-sample windows
    cfg(0, 1, 1);
    tick(1, 0);
    tick(1, -77);
    check("r27_sum", adcout_sum, -77);
    check("r27_avg", adcout_avg, -77);
    tick(0, 0);

    // random run
    for (int i = 0; i < 4000; i++) begin
      cfg($urandom_range(0, 4), $urandom_range(0, 15),
          $urandom_range(0, 15));
      tick(($urandom_range(0, 99) < 95), int'($urandom_range(0, 255)) - 128);
    end
    tick(0, 0);

    // reset mid-window
    cfg(3, 0, 0);
    tick(1, 0);
    for (int i = 0; i < 8; i++) tick(1, 3);
    tick(1, 0);
    for (int i = 0; i < 3; i++) tick(1, 5);
    #2 rstb = 1'b0;
    model_reset();
    #1;
    check_all("r37_async");
    @(posedge clk);
    #1;
    check_all("r37_held");
    #2 rstb = 1'b1;
    en = 1'b0;
    tick(0, 0);

    // worst-case window for overflow
    cfg(15, 0, 0);
    tick(1, 0);
    for (int i = 0; i < 32768; i++) tick(1, -128);
    check("r28_sum", adcout_sum, -4194304);
    check("r28_avg", adcout_avg, -128);
    tick(0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
